// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: one load/store at a time over valid/ready, with setup/strobe/hold
// sequencing toward an 8-bit memory, an address range check and saturating access counters.
module dmem_access_ctrl #(
  parameter int MEM_DEPTH = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [7:0]       req_addr,
  input  logic [7:0]       req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_rdata,
  output logic             rsp_err,
  output logic [7:0]       mem_address,
  output logic [7:0]       mem_write_data,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [7:0]       mem_read_data,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_CAPT, WR_SETUP, WR_STROBE, WR_HOLD, RESP
  } state_t;

  localparam logic [8:0]       DEPTH9  = 9'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  logic             req_ready_q, rsp_valid_q, rsp_err_q, last_write_q;
  logic             mem_read_q, mem_write_q;
  logic [7:0]       rsp_rdata_q, mem_address_q, mem_write_data_q;
  logic [CNT_W-1:0] rd_count_q, wr_count_q, err_count_q;
  logic             addr_ok;

  assign addr_ok = ({1'b0, req_addr} < DEPTH9);

  // Address and write data are loaded at accept and then left untouched until the next
  // accepted request, so they are stable around the single-cycle write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_rdata_q      <= '0;
      last_write_q     <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      rd_count_q       <= '0;
      wr_count_q       <= '0;
      err_count_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            req_ready_q  <= 1'b0;
            last_write_q <= req_write;
            if (!addr_ok) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              if (err_count_q != CNT_MAX) err_count_q <= err_count_q + 1'b1;
            end else if (req_write) begin
              state_q          <= WR_SETUP;
              mem_address_q    <= req_addr;
              mem_write_data_q <= req_wdata;
            end else begin
              state_q       <= RD_SETUP;
              mem_address_q <= req_addr;
              mem_read_q    <= 1'b1;
            end
          end
        end
        RD_SETUP: state_q <= RD_CAPT;
        RD_CAPT: begin
          state_q     <= RESP;
          mem_read_q  <= 1'b0;
          rsp_rdata_q <= mem_read_data;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
        end
        WR_SETUP: begin
          state_q     <= WR_STROBE;
          mem_write_q <= 1'b1;
        end
        WR_STROBE: begin
          state_q     <= WR_HOLD;
          mem_write_q <= 1'b0;
        end
        WR_HOLD: begin
          state_q     <= RESP;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            // Rejected requests were already counted when they were accepted.
            if (!rsp_err_q) begin
              if (last_write_q) begin
                if (wr_count_q != CNT_MAX) wr_count_q <= wr_count_q + 1'b1;
              end else begin
                if (rd_count_q != CNT_MAX) rd_count_q <= rd_count_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset/backpressure/saturation sequences
// and randomized traffic scored against a simple memory-and-counter reference model.
module tb_dmem_access_ctrl;

  localparam int MEM_DEPTH = 10;
  localparam int CNT_W     = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_write;
  logic [7:0]       req_addr, req_wdata;
  logic             rsp_valid, rsp_ready, rsp_err;
  logic [7:0]       rsp_rdata;
  logic [7:0]       mem_address, mem_write_data, mem_read_data;
  logic             mem_read, mem_write;
  logic [CNT_W-1:0] rd_count, wr_count, err_count;

  logic             initMem;
  logic [7:0]       envMem [0:255];
  logic [7:0]       refMem [0:255];
  int               checks = 0;
  int               failures = 0;
  int               mRd = 0, mWr = 0, mErr = 0;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         stall;
    logic [7:0] expData;
    logic       expErr;
    int         expLat;
  } vec_t;

  vec_t vecs [8];

  dmem_access_ctrl #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data),
    .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Behavioural memory seen by the controller: asynchronous read, write on the clock edge.
  always @(posedge clk) begin
    if (initMem) begin
      for (int i = 0; i < 256; i++) envMem[i] <= 8'(i * 7 + 1);
    end else if (mem_write) begin
      envMem[mem_address] <= mem_write_data;
    end
  end
  assign mem_read_data = envMem[mem_address];

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      failures++;
      $display("[TB] FAIL strobeOverlap: mem_read=%0b mem_write=%0b, required never both 1", mem_read, mem_write);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int sat(input int x);
    return (x >= 255) ? 255 : x + 1;
  endfunction

  function automatic void modelAccess(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                                      output logic [7:0] expData, output logic expErr);
    expData = 8'h00;
    expErr  = 1'b0;
    if (int'(addr) >= MEM_DEPTH) expErr = 1'b1;
    else if (wr) refMem[addr] = wdata;
    else expData = refMem[addr];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one request from accept to response handshake, checking the memory-side sequencing,
  // backpressure stability and counters along the way. Entered and left #1 after a rising edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input int stall, output logic [7:0] gotData, output logic gotErr,
                               output int gotLat);
    int  k;
    bit  isErr;
    isErr   = (int'(addr) >= MEM_DEPTH);
    gotData = 8'h00;
    gotErr  = 1'b0;
    gotLat  = -1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
    if (isErr) mErr = sat(mErr);
    for (k = 1; k <= 20; k++) begin
      if (isErr) begin
        checkOutput("errNoRead", 32'(mem_read), 32'd0);
        checkOutput("errNoWrite", 32'(mem_write), 32'd0);
      end else if (wr && k <= 3) begin
        checkOutput("wrStrobe", 32'(mem_write), 32'(k == 2));
        checkOutput("wrNoRead", 32'(mem_read), 32'd0);
        checkOutput("wrAddr", 32'(mem_address), 32'(addr));
        checkOutput("wrData", 32'(mem_write_data), 32'(wdata));
      end else if (!wr && k <= 2) begin
        checkOutput("rdStrobe", 32'(mem_read), 32'd1);
        checkOutput("rdAddr", 32'(mem_address), 32'(addr));
      end
      if (rsp_valid) break;
      @(posedge clk); #1;
    end
    if (!rsp_valid) begin
      checkOutput("rspTimeout", 32'(rsp_valid), 32'd1);
      return;
    end
    gotLat  = k;
    gotData = rsp_rdata;
    gotErr  = rsp_err;
    checkOutput("respStrobesLow", {30'd0, mem_read, mem_write}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      checkOutput("stallValid", 32'(rsp_valid), 32'd1);
      checkOutput("stallData", 32'(rsp_rdata), 32'(gotData));
      checkOutput("stallErr", 32'(rsp_err), 32'(gotErr));
      checkOutput("stallReqReady", 32'(req_ready), 32'd0);
      checkOutput("stallRdCount", 32'(rd_count), 32'(mRd));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (!isErr) begin
      if (wr) mWr = sat(mWr);
      else    mRd = sat(mRd);
    end
    checkOutput("rspDropped", 32'(rsp_valid), 32'd0);
    checkOutput("rdCount", 32'(rd_count), 32'(mRd));
    checkOutput("wrCount", 32'(wr_count), 32'(mWr));
    checkOutput("errCount", 32'(err_count), 32'(mErr));
  endtask

  initial begin
    logic [7:0] gotData, expData;
    logic       gotErr, expErr;
    int         gotLat, expLat, stall;
    logic       wr;
    logic [7:0] addr, wdata;

    vecs[0] = '{1'b1, 8'd3,   8'hA5, 0, 8'h00, 1'b0, 4};
    vecs[1] = '{1'b0, 8'd3,   8'h00, 0, 8'hA5, 1'b0, 3};
    vecs[2] = '{1'b0, 8'd10,  8'h00, 0, 8'h00, 1'b1, 1};
    vecs[3] = '{1'b1, 8'hFF,  8'h11, 0, 8'h00, 1'b1, 1};
    vecs[4] = '{1'b0, 8'd0,   8'h00, 5, 8'h01, 1'b0, 3};
    vecs[5] = '{1'b0, 8'd9,   8'h00, 0, 8'h40, 1'b0, 3};
    vecs[6] = '{1'b1, 8'd9,   8'h3C, 2, 8'h00, 1'b0, 4};
    vecs[7] = '{1'b0, 8'd9,   8'h00, 0, 8'h3C, 1'b0, 3};

    for (int i = 0; i < 256; i++) refMem[i] = 8'(i * 7 + 1);
    reset = 1'b1; initMem = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; initMem = 1'b0;
    checkOutput("rstReqReady", 32'(req_ready), 32'd1);
    checkOutput("rstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("rstRspData", {23'd0, rsp_err, rsp_rdata}, 32'd0);
    checkOutput("rstMemBus", {16'd0, mem_address, mem_write_data}, 32'd0);
    checkOutput("rstStrobes", {30'd0, mem_read, mem_write}, 32'd0);
    checkOutput("rstCounts", {8'd0, rd_count, wr_count, err_count}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      modelAccess(vecs[i].wr, vecs[i].addr, vecs[i].wdata, expData, expErr);
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].stall, gotData, gotErr, gotLat);
      checkOutput($sformatf("vec%0dData", i), 32'(gotData), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0dErr", i), 32'(gotErr), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0dLat", i), 32'(gotLat), 32'(vecs[i].expLat));
    end
    checkOutput("tableCounts", {8'd0, rd_count, wr_count, err_count}, {8'd0, 8'd4, 8'd2, 8'd2});

    // Reset while the write strobe is high: the write itself lands, the response is dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd5; req_wdata = 8'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("preRstStrobe", 32'(mem_write), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midRstWrite", 32'(mem_write), 32'd0);
    checkOutput("midRstRead", 32'(mem_read), 32'd0);
    checkOutput("midRstReqReady", 32'(req_ready), 32'd1);
    checkOutput("midRstRspValid", 32'(rsp_valid), 32'd0);
    checkOutput("midRstCounts", {8'd0, rd_count, wr_count, err_count}, 32'd0);
    refMem[5] = 8'h77;
    mRd = 0; mWr = 0; mErr = 0;
    modelAccess(1'b0, 8'd5, 8'h00, expData, expErr);
    applyStimulus(1'b0, 8'd5, 8'h00, 0, gotData, gotErr, gotLat);
    checkOutput("postRstLoad", 32'(gotData), 32'h77);

    for (int i = 0; i < 260; i++) begin
      modelAccess(1'b0, 8'd9, 8'h00, expData, expErr);
      applyStimulus(1'b0, 8'd9, 8'h00, 0, gotData, gotErr, gotLat);
      if (gotData !== expData || gotErr !== 1'b0) checkOutput("satLoad", {23'd0, gotErr, gotData}, {23'd0, 1'b0, expData});
    end
    checkOutput("satRdCount", 32'(rd_count), 32'd255);

    for (int i = 0; i < 1000; i++) begin
      wr    = 1'($urandom);
      addr  = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 11));
      wdata = 8'($urandom);
      stall = int'($urandom_range(0, 3));
      modelAccess(wr, addr, wdata, expData, expErr);
      expLat = expErr ? 1 : (wr ? 4 : 3);
      applyStimulus(wr, addr, wdata, stall, gotData, gotErr, gotLat);
      checkOutput("rndData", 32'(gotData), 32'(expData));
      checkOutput("rndErr", 32'(gotErr), 32'(expErr));
      checkOutput("rndLat", 32'(gotLat), 32'(expLat));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
